// File: rtl/adder_tree_pkg.sv
// Shared types for the adder tree front end: sample width and the loader bank states.
package adder_tree_pkg;

  localparam int SAMPLE_W = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

  // A frame closes on in_last or when the final slot is written.
  function automatic logic frame_closes(input logic last, input logic at_end);
    return last | at_end;
  endfunction

endpackage

// File: rtl/adder_tree_loader_bank.sv
// One frame buffer: N sample slots, write index, sample count and FILL/HOLD state.
module loader_bank
  import adder_tree_pkg::*;
#(
  parameter int N = 4,
  parameter int L = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              wr_last,
  input  logic              rel,
  output logic              closing,
  output logic [8*N-1:0]    slots,
  output logic [L:0]        count,
  output loader_state_t     state
);

  loader_state_t        state_q, state_d;
  logic [L-1:0]         wr_idx_q, wr_idx_d;
  logic [N-1:0][7:0]    slot_q, slot_d;
  logic [L:0]           count_q, count_d;

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    slot_d   = slot_q;
    count_d  = count_q;
    closing  = 1'b0;
    case (state_q)
      FILL: begin
        if (wr_en) begin
          slot_d[wr_idx_q] = wr_data;
          wr_idx_d         = wr_idx_q + 1'b1;
          if (frame_closes(wr_last, wr_idx_q == L'(N-1))) begin
            closing = 1'b1;
            state_d = HOLD;
            count_d = {1'b0, wr_idx_q} + 1'b1;
          end
        end
      end
      HOLD: begin
        // Clearing every slot on release is what makes short frames zero-padded.
        if (rel) begin
          state_d  = FILL;
          wr_idx_d = '0;
          slot_d   = '0;
          count_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FILL;
      wr_idx_q <= '0;
      slot_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      slot_q   <= slot_d;
      count_q  <= count_d;
    end
  end

  assign slots = slot_q;
  assign count = count_q;
  assign state = state_q;

endmodule

// File: rtl/adder_tree_loader.sv
// Serial-to-parallel loader feeding the adder tree stage_zero vector.
// Build option ADDER_TREE_LOADER_DOUBLE_BUF_EN selects ping-pong banks instead of one bank.
module adder_tree_loader
  import adder_tree_pkg::*;
#(
  parameter int  N = 4,
  localparam int L = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*N-1:0]    stage_zero,
  output logic [L:0]        out_count
);

  // Handshakes: a beat/frame transfers on a rising edge where valid and ready are
  // both 1; out_valid, stage_zero and out_count hold until that transfer happens.
  logic accept;
  logic release_frame;

  assign accept        = in_valid & in_ready;
  assign release_frame = out_valid & out_ready;

`ifdef ADDER_TREE_LOADER_DOUBLE_BUF_EN

  logic            wr_sel_q, wr_sel_d;
  logic            rd_sel_q, rd_sel_d;
  logic [1:0]      bank_close;
  logic [8*N-1:0]  bank_slots [2];
  logic [L:0]      bank_count [2];
  loader_state_t   bank_state [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    loader_bank #(.N(N), .L(L)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && (wr_sel_q == 1'(b))),
      .wr_data (in_data),
      .wr_last (in_last),
      .rel     (release_frame && (rd_sel_q == 1'(b))),
      .closing (bank_close[b]),
      .slots   (bank_slots[b]),
      .count   (bank_count[b]),
      .state   (bank_state[b])
    );
  end

  // Write and read pointers each toggle once per frame, so frames leave in fill order.
  always_comb begin
    wr_sel_d   = wr_sel_q ^ (|bank_close);
    rd_sel_d   = rd_sel_q ^ release_frame;
    in_ready   = (bank_state[wr_sel_q] == FILL);
    out_valid  = (bank_state[rd_sel_q] == HOLD);
    stage_zero = bank_slots[rd_sel_q];
    out_count  = bank_count[rd_sel_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

`else

  loader_state_t   bank_state;
  logic [8*N-1:0]  bank_slots;
  logic [L:0]      bank_count;
  logic            close_unused;

  loader_bank #(.N(N), .L(L)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (in_data),
    .wr_last (in_last),
    .rel     (release_frame),
    .closing (close_unused),
    .slots   (bank_slots),
    .count   (bank_count),
    .state   (bank_state)
  );

  always_comb begin
    in_ready   = (bank_state == FILL);
    out_valid  = (bank_state == HOLD);
    stage_zero = bank_slots;
    out_count  = bank_count;
  end

`endif

endmodule
